game_match_sequencer: RTL and testbench
=======================================

// Module: game_match_sequencer
// PURPOSE
//  Synthesizable driver for the full_game port set: drives init/initial_val/control
//  and consumes gameover/who. Runs a best-of match of repeated rounds.
//  Scores each round's winner and reports the match result. Sits between
//  board-level inputs (buttons/switches) and full_game, replacing a hand-driven stimulus.
// PARAMETERS
//  WIN_TARGET  3     round wins needed to take the match (1..(2**WIN_W)-1)
//  WIN_W       3     width of each win counter
//  INIT_CYCLES 2     cycles init is held high per round load (>=1)
//  TIMEOUT     1024  max PLAY cycles before a round aborts (>=2)
//  ROTATE      1     1: control increments mod 4 each new round; 0: fixed
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  start        in   1      1-cycle pulse: begin match (ignored while busy)
//  abort        in   1      sync: end match immediately, go IDLE
//  mode_in      in   2      control mode latched on start
//  seed_in      in   4      initial_val latched on start
//  gameover     in   1      from full_game
//  who          in   1      from full_game: 0 = player A won, 1 = player B won
//  init         out  1      to full_game: load/restart
//  initial_val  out  4      to full_game
//  control      out  2      to full_game
//  busy         out  1      high in any state except IDLE/DONE
//  match_done   out  1      high in DONE
//  match_winner out  1      0 = A, 1 = B; valid while match_done
//  timeout      out  1      sticky: a round hit TIMEOUT; cleared on start
//  wins_a       out  WIN_W  rounds won by A
//  wins_b       out  WIN_W  rounds won by B
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; round/timer counters 0;
//   gameover edge register gov_q=0.
//  gov_q <= gameover every cycle; round-win event rise = gameover & ~gov_q.
//  FSM (all transitions on clk rising edge):
//   IDLE : start -> LOAD. Latch seed_in/mode_in; clear wins, timeout, match_done.
//   LOAD : init=1, initial_val=seed, control=mode_reg for INIT_CYCLES cycles,
//          then -> PLAY; PLAY timer cleared.
//   PLAY : init=0; timer++. rise -> SCORE. Timer==TIMEOUT-1 without rise:
//          timeout<=1, -> LOAD (replay round, no score, control not rotated).
//   SCORE: 1 cycle. who=0: wins_a++, else wins_b++. If the new count equals
//          WIN_TARGET -> DONE with match_winner=who; else -> LOAD and,
//          if ROTATE, mode_reg <= mode_reg+1 (wraps 3->0).
//   DONE : match_done=1, busy=0, init=0; outputs hold. start -> LOAD (new match;
//          clears wins, timeout, match_done).
//  A rise seen in LOAD is ignored (game held in init); gov_q still updates.
//  gameover already high on entry to PLAY gives no rise; only a fresh 0->1 scores.
//  abort (any state) -> IDLE next cycle; init=0, busy=0, match_done=0; wins held.
//  abort has priority over start and rise in the same cycle.
//  start while busy: ignored. Win counters never exceed WIN_TARGET (no wrap).
//  Reset mid-round: immediate return to reset values; full_game sees init=0.
//  Latency: start -> first init=1 in 1 cycle; rise -> wins update 1 cycle later.
// TESTING
//  1 Reset mid-PLAY (rst_n low 3 cycles) -> all outputs 0 asynchronously; state IDLE.
//  2 start, seed=4'h5, mode=2'b01 -> init high 2 cycles with initial_val=5,
//    control=01; then init=0, busy=1.
//  3 Model 3 gameover pulses with who=1,0,1, then 1 -> wins_b=3, wins_a=1;
//    match_done=1, match_winner=1; control seen per round 01,10,11,00.
//  4 No gameover for 1024 PLAY cycles -> timeout=1, re-LOAD with the same control;
//    wins unchanged.
//  5 abort and rise in the same PLAY cycle -> IDLE, no score change; start
//    during busy has no effect.
//  6 gameover held high across LOAD into PLAY -> no score until it falls and rises again.

Source files
------------

// File: rtl/game_match_sequencer_if.sv
// Link between the match sequencer and full_game: load/restart controls
// flow out of the sequencer, game result flags flow back in.
interface game_match_sequencer_if;
  logic       init;
  logic [3:0] initial_val;
  logic [1:0] control;
  logic       gameover;
  logic       who;

  modport master (output init, initial_val, control, input gameover, who);
  modport slave  (input init, initial_val, control, output gameover, who);
endinterface

// File: rtl/game_match_sequencer.sv
// Best-of match sequencer for full_game: loads each round, watches for a
// fresh gameover edge, scores the winner and reports the match result.
module game_match_sequencer #(
  parameter int WIN_TARGET  = 3,
  parameter int WIN_W       = 3,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int ROTATE      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode_in,
  input  logic [3:0]                seed_in,
  game_match_sequencer_if.master    game,
  output logic                      busy,
  output logic                      match_done,
  output logic                      match_winner,
  output logic                      timeout,
  output logic [WIN_W-1:0]          wins_a,
  output logic [WIN_W-1:0]          wins_b
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_SCORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int ICW = $clog2(INIT_CYCLES + 1);

  localparam logic [TW-1:0]    TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ICW-1:0]   INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [WIN_W-1:0] TARGET    = WIN_W'(WIN_TARGET);

  logic [2:0]       state_q, state_d;
  logic             gov_q;
  logic [3:0]       seed_q, seed_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIN_W-1:0] wa_q, wa_d, wb_q, wb_d;
  logic             to_q, to_d;
  logic             win_q, win_d;
  logic [ICW-1:0]   icnt_q, icnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             rise;
  logic [WIN_W-1:0] wins_inc;

  assign rise     = game.gameover & ~gov_q;
  assign wins_inc = (game.who ? wb_q : wa_q) + 1'b1;

  // Next-state and datapath updates; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    to_d    = to_q;
    win_d   = win_q;
    icnt_d  = icnt_q;
    tmr_d   = tmr_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD;
            seed_d  = seed_in;
            mode_d  = mode_in;
            wa_d    = '0;
            wb_d    = '0;
            to_d    = 1'b0;
            win_d   = 1'b0;
            icnt_d  = '0;
          end
        end
        S_LOAD: begin
          if (icnt_q == INIT_LAST) begin
            state_d = S_PLAY;
            tmr_d   = '0;
          end else begin
            icnt_d = icnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          tmr_d = tmr_q + 1'b1;
          if (rise) begin
            state_d = S_SCORE;
          end else if (tmr_q == TMR_LAST) begin
            // Replay the same round: control is deliberately not rotated.
            to_d    = 1'b1;
            state_d = S_LOAD;
            icnt_d  = '0;
          end
        end
        S_SCORE: begin
          if (game.who) wb_d = wins_inc;
          else          wa_d = wins_inc;
          if (wins_inc == TARGET) begin
            state_d = S_DONE;
            win_d   = game.who;
          end else begin
            state_d = S_LOAD;
            icnt_d  = '0;
            if (ROTATE != 0) mode_d = mode_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers plus the gameover edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gov_q   <= 1'b0;
      seed_q  <= '0;
      mode_q  <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      to_q    <= 1'b0;
      win_q   <= 1'b0;
      icnt_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      gov_q   <= game.gameover;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      to_q    <= to_d;
      win_q   <= win_d;
      icnt_q  <= icnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    game.init        = (state_q == S_LOAD);
    game.initial_val = seed_q;
    game.control     = mode_q;
    busy             = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_SCORE);
    match_done       = (state_q == S_DONE);
    match_winner     = win_q;
    timeout          = to_q;
    wins_a           = wa_q;
    wins_b           = wb_q;
  end

endmodule

// File: tb/tb_game_match_sequencer.sv
// Randomized self-checking bench for game_match_sequencer with a
// round-level scoreboard of expected wins, control and flags.
module tb_game_match_sequencer;

  localparam int WIN_TARGET = 3;
  localparam int TIMEOUT    = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode_in = '0;
  logic [3:0] seed_in = '0;
  logic       busy, match_done, match_winner, timeout;
  logic [2:0] wins_a, wins_b;

  game_match_sequencer_if gif();

  game_match_sequencer #(
    .WIN_TARGET(WIN_TARGET), .WIN_W(3), .INIT_CYCLES(2), .TIMEOUT(TIMEOUT), .ROTATE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mode_in(mode_in), .seed_in(seed_in), .game(gif),
    .busy(busy), .match_done(match_done), .match_winner(match_winner),
    .timeout(timeout), .wins_a(wins_a), .wins_b(wins_b)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Scoreboard: what the match should look like at round granularity.
  int unsigned exp_a, exp_b, exp_ctl, exp_seed;
  bit          exp_to, exp_done, exp_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wins(input string tag);
    chk({tag, "_wa"}, 32'(wins_a), exp_a);
    chk({tag, "_wb"}, 32'(wins_b), exp_b);
  endtask

  task automatic start_match(input int unsigned seed, input int unsigned mode);
    seed_in = 4'(seed);
    mode_in = 2'(mode);
    start   = 1'b1;
    tick();
    start    = 1'b0;
    exp_a    = 0;
    exp_b    = 0;
    exp_to   = 1'b0;
    exp_done = 1'b0;
    exp_ctl  = mode % 4;
    exp_seed = seed % 16;
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(match_done), 0);
    chk("start_to", 32'(timeout), 0);
    chk_wins("start");
  endtask

  // Entered on the first LOAD cycle of a round; leaves on the next LOAD or DONE.
  task automatic play_round(input bit w, input int unsigned gap, input bit do_to);
    chk("load_init", 32'(gif.init), 1);
    chk("load_ctl", 32'(gif.control), exp_ctl);
    chk("load_seed", 32'(gif.initial_val), exp_seed);
    tick();
    chk("load_init2", 32'(gif.init), 1);
    tick();
    chk("play_init", 32'(gif.init), 0);
    chk("play_busy", 32'(busy), 1);
    if (do_to) begin
      repeat (TIMEOUT - 1) tick();
      chk("pre_to_init", 32'(gif.init), 0);
      chk("pre_to_flag", 32'(timeout), 32'(exp_to));
      tick();
      exp_to = 1'b1;
      chk("to_flag", 32'(timeout), 1);
      chk("to_reload", 32'(gif.init), 1);
      chk("to_ctl", 32'(gif.control), exp_ctl);
      chk_wins("to");
      tick();
      tick();
      chk("to_play", 32'(gif.init), 0);
    end
    repeat (gap) tick();
    gif.who      = w;
    gif.gameover = 1'b1;
    tick();
    chk_wins("score_pending");
    tick();
    gif.gameover = 1'b0;
    if (w) exp_b++;
    else   exp_a++;
    chk_wins("scored");
    chk("scored_to", 32'(timeout), 32'(exp_to));
    if (exp_a == WIN_TARGET || exp_b == WIN_TARGET) begin
      exp_done = 1'b1;
      exp_win  = w;
      chk("done_flag", 32'(match_done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_winner", 32'(match_winner), 32'(w));
      chk("done_init", 32'(gif.init), 0);
      chk("done_ctl", 32'(gif.control), exp_ctl);
    end else begin
      exp_ctl = (exp_ctl + 1) % 4;
      chk("next_done", 32'(match_done), 0);
      chk("next_busy", 32'(busy), 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_init"}, 32'(gif.init), 0);
    chk({tag, "_ival"}, 32'(gif.initial_val), 0);
    chk({tag, "_ctl"}, 32'(gif.control), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(match_done), 0);
    chk({tag, "_win"}, 32'(match_winner), 0);
    chk({tag, "_to"}, 32'(timeout), 0);
    chk({tag, "_wa"}, 32'(wins_a), 0);
    chk({tag, "_wb"}, 32'(wins_b), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [3:0] tags [4];
    gif.gameover = 1'b0;
    gif.who      = 1'b0;
    #1;
    chk_all_zero("por");
    #22 rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Reset in the middle of a round.
    start_match(2, 0);
    play_round(1'b1, 3, 1'b0);
    tick();
    tick();
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_init", 32'(gif.init), 0);

    // Directed match: seed 5, mode 01, winners B,A,B,B.
    start_match(5, 1);
    tags[0] = 4'h1; tags[1] = 4'h0; tags[2] = 4'h1; tags[3] = 4'h1;
    for (int i = 0; i < 4; i++) play_round(tags[i][0], 2, 1'b0);
    chk("dir_done", 32'(exp_done), 1);
    chk("dir_wa", 32'(wins_a), 1);
    chk("dir_wb", 32'(wins_b), 3);

    // Timeout replays the round without scoring or rotating.
    start_match(10, 2);
    play_round(1'b0, 1, 1'b0);
    play_round(1'b1, 4, 1'b1);
    repeat (3) tick();
    chk("to_sticky", 32'(timeout), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_to_busy", 32'(busy), 0);

    // Busy start is ignored; abort beats a simultaneous rise and start.
    start_match(3, 0);
    play_round(1'b0, 2, 1'b0);
    tick();
    tick();
    seed_in = 4'hF;
    mode_in = 2'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_busy", 32'(busy), 1);
    chk("busy_start_init", 32'(gif.init), 0);
    chk("busy_start_seed", 32'(gif.initial_val), exp_seed);
    chk("busy_start_ctl", 32'(gif.control), exp_ctl);
    gif.who      = 1'b1;
    gif.gameover = 1'b1;
    abort        = 1'b1;
    start        = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_init", 32'(gif.init), 0);
    chk("abort_done", 32'(match_done), 0);
    chk_wins("abort");
    tick();
    tick();
    chk("abort_idle", 32'(busy), 0);
    chk_wins("abort_held");
    gif.gameover = 1'b0;
    tick();

    // gameover held high from the scoring edge through LOAD into PLAY.
    start_match(9, 3);
    tick();
    tick();
    gif.who      = 1'b0;
    gif.gameover = 1'b1;
    tick();
    tick();
    exp_a   = 1;
    exp_ctl = 0;
    chk_wins("held_first");
    chk("held_ctl", 32'(gif.control), exp_ctl);
    tick();
    tick();
    repeat (5) tick();
    chk("held_play", 32'(gif.init), 0);
    chk("held_busy", 32'(busy), 1);
    chk_wins("held_no_score");
    gif.gameover = 1'b0;
    tick();
    gif.who      = 1'b1;
    gif.gameover = 1'b1;
    tick();
    tick();
    gif.gameover = 1'b0;
    exp_b   = 1;
    exp_ctl = 1;
    chk_wins("held_rescore");
    play_round(1'b0, 1, 1'b0);
    play_round(1'b0, 1, 1'b0);
    chk("held_match_done", 32'(match_done), 1);

    // Randomized matches, each started from DONE.
    for (int m = 0; m < 6; m++) begin
      start_match($urandom_range(15, 0), $urandom_range(3, 0));
      while (!exp_done)
        play_round(1'($urandom_range(1, 0)), $urandom_range(15, 0), ($urandom_range(7, 0) == 0));
      tick();
      chk("rand_hold_done", 32'(match_done), 1);
      chk("rand_hold_win", 32'(match_winner), 32'(exp_win));
      chk_wins("rand_hold");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
